// File: rtl/dmem_line_ctrl.sv
// dmem_line_ctrl: line-granular data-memory controller behind the 2-way data cache.
// Serves 64-bit line fills and write-backs after a fixed LATENCY, with a busy/done
// handshake for the miss sequencer. Backing store is an internal line array.
// Optional feature macro: DMEM_STATS_EN adds rd_cnt/wr_cnt completion counters.
module dmem_line_ctrl #(
    parameter int LATENCY    = 4,
    parameter int LINE_IDX_W = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        readM2,
    input  logic        writeM2,
    input  logic [15:0] address2,
    input  logic [63:0] wr_line,
    output logic [63:0] rd_line,
    output logic        busy,
    output logic        done,
    output logic        done_wr
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt
`endif
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_line_ctrl: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_nx;
    logic                    r_op;        // 1 = write-back, 0 = line fill
    logic                    r_pend_rd;   // read queued behind a simultaneous write
    logic [LINE_IDX_W-1:0]   r_idx;
    logic [63:0]             r_data;
    logic [63:0]             r_rd_line;
    logic [63:0]             r_mem [0:(2**LINE_IDX_W)-1];
    logic                    w_accept;
    logic                    w_chain;
    logic                    w_done;
    logic                    w_busy;
    logic                    w_unused_addr;

    // Upper address bits alias onto the array and the word offset is ignored.
    assign w_unused_addr = ^{address2[15:LINE_IDX_W+2], address2[1:0]};

    // State register plus latched operation type and queued-read flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_op      <= 1'b0;
            r_pend_rd <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_accept) begin
                r_op      <= writeM2;
                r_pend_rd <= readM2 && writeM2;
            end else if (w_chain) begin
                r_op      <= 1'b0;
                r_pend_rd <= 1'b0;
            end
        end
    end

    // Next-state, latency countdown and handshake outputs.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_accept   = 1'b0;
        w_chain    = 1'b0;
        w_done     = 1'b0;
        w_busy     = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (readM2 || writeM2) begin
                    w_accept   = 1'b1;
                    w_state_nx = S_BUSY;
                    w_cnt_nx   = LAT_M1;
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (r_pend_rd) begin
                    w_chain    = 1'b1;
                    w_state_nx = S_BUSY;
                    w_cnt_nx   = LAT_M1;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Capture line index and write data when a request is accepted (data path, no reset).
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx  <= address2[LINE_IDX_W+1:2];
            r_data <= wr_line;
        end
    end

    // Commit write-backs in the DONE cycle; a reset in that cycle cancels the commit.
    always_ff @(posedge clk) begin
        if (reset_n && w_done && r_op) begin
            r_mem[r_idx] <= r_data;
        end
    end

    // Read data register: loads on fill completion, otherwise holds.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_line <= 64'd0;
        end else if (w_done && !r_op) begin
            r_rd_line <= r_mem[r_idx];
        end
    end

`ifdef DMEM_STATS_EN
    logic [15:0] r_rd_cnt;
    logic [15:0] r_wr_cnt;

    // Completion counters, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_cnt <= 16'd0;
            r_wr_cnt <= 16'd0;
        end else if (w_done) begin
            if (r_op) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end else begin
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end
        end
    end

    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;
`endif

    assign rd_line = r_rd_line;
    assign busy    = w_busy;
    assign done    = w_done;
    assign done_wr = w_done && r_op;

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Scoreboard bench for dmem_line_ctrl: a driver issues requests and pushes the
// expected completions (type, cycle, data) from a line-array model; a monitor
// on the falling edge pops and compares whenever done pulses.
module tb_dmem_line_ctrl;

    localparam int L = 4;

    logic        clk;
    logic        reset_n;
    logic        readM2;
    logic        writeM2;
    logic [15:0] address2;
    logic [63:0] wr_line;
    logic [63:0] rd_line;
    logic        busy;
    logic        done;
    logic        done_wr;
`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
`endif

    dmem_line_ctrl #(.LATENCY(L), .LINE_IDX_W(6)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .readM2   (readM2),
        .writeM2  (writeM2),
        .address2 (address2),
        .wr_line  (wr_line),
        .rd_line  (rd_line),
        .busy     (busy),
        .done     (done),
        .done_wr  (done_wr)
`ifdef DMEM_STATS_EN
        ,
        .rd_cnt   (rd_cnt),
        .wr_cnt   (wr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        int          cyc;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mem_m [64];
    int          cyc = 0;
    int          nchecks = 0;
    int          npass = 0;
    logic [63:0] exp_rd = 64'd0;
    bit          rd_upd = 1'b0;
    logic [63:0] rd_new = 64'd0;
    int          n_rd_m = 0;
    int          n_wr_m = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        nchecks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: compare every completion against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rd_upd) begin
                exp_rd = rd_new;
                rd_upd = 1'b0;
            end
            chk("rd_line_hold", rd_line, exp_rd);
            if (sb.size() > 0) chk("busy_outstanding", {63'd0, busy}, 64'd1);
            if (done) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_wr", {63'd0, done_wr}, {63'd0, e.wr});
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.wr) n_wr_m++;
                    else begin
                        n_rd_m++;
                        rd_upd = 1'b1;
                        rd_new = e.data;
                    end
                end
            end else begin
                chk("done_wr_idle", {63'd0, done_wr}, 64'd0);
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy || sb.size() > 0) begin
            @(posedge clk); #1;
            t++;
            if (t > 200) begin
                fail_now("timeout_waiting_idle");
                break;
            end
        end
    endtask

    // Issue one request at an idle controller; optionally wiggle inputs while it is busy.
    task automatic issue(input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [63:0] data, input bit garble);
        int idx;
        int span;
        wait_idle();
        readM2 = rd; writeM2 = wr; address2 = addr; wr_line = data;
        @(posedge clk); #1;
        idx = int'(addr[7:2]);
        if (wr) begin
            mem_m[idx] = data;
            sb.push_back('{wr: 1'b1, cyc: cyc + L, data: data});
        end
        if (rd) sb.push_back('{wr: 1'b0, cyc: wr ? cyc + 2*L + 1 : cyc + L, data: mem_m[idx]});
        span = (rd && wr) ? 2*L + 1 : L;
        for (int k = 0; k <= span; k++) begin
            if (garble) begin
                readM2   = 1'($urandom());
                writeM2  = 1'($urandom());
                address2 = 16'($urandom());
                wr_line  = {$urandom(), $urandom()};
            end else begin
                readM2 = 1'b0; writeM2 = 1'b0;
            end
            @(posedge clk); #1;
        end
        readM2 = 1'b0; writeM2 = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        exp_rd  = 64'd0;
        rd_upd  = 1'b0;
        n_rd_m  = 0;
        n_wr_m  = 0;
        repeat (n) begin @(posedge clk); #1; end
        reset_n = 1'b1;
    endtask

    initial begin
        logic [63:0] prior5;
        readM2 = 1'b0; writeM2 = 1'b0; address2 = 16'd0; wr_line = 64'd0;
        reset_n = 1'b0;
        #1;
        do_reset(2);
        @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_done_wr", {63'd0, done_wr}, 64'd0);
        chk("reset_rd_line", rd_line, 64'd0);
        @(posedge clk); #1;

        // Fill every line so later reads have defined contents.
        for (int i = 0; i < 64; i++)
            issue(1'b0, 1'b1, 16'(i * 4), {$urandom(), $urandom()}, 1'($urandom()));

        // Directed: write then read within the same line, different word offsets.
        issue(1'b0, 1'b1, 16'h0010, 64'h1111_2222_3333_4444, 1'b0);
        issue(1'b1, 1'b0, 16'h0013, 64'd0, 1'b0);
        // Simultaneous read and write.
        issue(1'b1, 1'b1, 16'h0024, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
        // Aliasing of upper address bits.
        issue(1'b0, 1'b1, 16'h0100, 64'h0123_4567_89AB_CDEF, 1'b1);
        issue(1'b1, 1'b0, 16'h0000, 64'd0, 1'b1);
        wait_idle();

        // Reset in the second BUSY cycle of a write to idx 5: nothing completes or commits.
        prior5 = mem_m[5];
        readM2 = 1'b0; writeM2 = 1'b1; address2 = 16'h0014; wr_line = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk); #1;
        writeM2 = 1'b0;
        @(posedge clk); #1;
        do_reset(2);
        repeat (L + 3) begin @(posedge clk); #1; end
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_rd_line", rd_line, 64'd0);
        issue(1'b1, 1'b0, 16'h0014, 64'd0, 1'b0);
        wait_idle();
        @(posedge clk); #1;
        chk("midreset_prior_contents", rd_line, prior5);

        // Randomized traffic over the full address space.
        for (int i = 0; i < 60; i++) begin
            int op;
            op = int'($urandom_range(0, 2));
            issue(op != 1, op != 0, 16'($urandom()), {$urandom(), $urandom()}, 1'($urandom()));
        end
        wait_idle();
        repeat (2) begin @(posedge clk); #1; end

`ifdef DMEM_STATS_EN
        chk("rd_cnt", {48'd0, rd_cnt}, 64'(n_rd_m));
        chk("wr_cnt", {48'd0, wr_cnt}, 64'(n_wr_m));
`endif

        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

endmodule
